// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush, hazard and exception-sequencing controller for the 4-stage core.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int               ADDR_W     = 30,
    parameter int               REG_W      = 5,
    parameter int               EXP_W      = 3,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 30'h0000_0010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic [REG_W-1:0]  id_src0_addr,
    input  logic [REG_W-1:0]  id_src1_addr,
    input  logic [1:0]        id_src_use,
    input  logic              id_br_taken,
    input  logic              ex_en,
    input  logic              ex_is_load,
    input  logic              ex_gpr_we_,
    input  logic [REG_W-1:0]  ex_dst_addr,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic [EXP_W-1:0]  mem_exp_code,
    input  logic              mem_eret,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              new_pc_vld,
    output logic [ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]  exp_cause,
    output logic              in_handler
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       to_vec;
    logic       gs;
    logic       lu;
    logic       exc;
    logic       eret;
    logic       run_ok;

    assign gs     = if_busy | mem_busy;
    assign exc    = mem_en & (mem_exp_code != '0);
    assign eret   = mem_en & mem_eret & ~exc;
    assign run_ok = (state == RUN) & ~gs;

    assign lu = ex_en & ex_is_load & ~ex_gpr_we_ & (ex_dst_addr != '0) &
                ((id_src_use[0] & (id_src0_addr == ex_dst_addr)) |
                 (id_src_use[1] & (id_src1_addr == ex_dst_addr)));

    always_comb begin
        if_stall   = 1'b0;
        id_stall   = 1'b0;
        ex_stall   = 1'b0;
        mem_stall  = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        ex_flush   = 1'b0;
        mem_flush  = 1'b0;
        new_pc_vld = 1'b0;
        state_nxt  = state;
        if (gs) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (state == REDIRECT) begin
            new_pc_vld = 1'b1;
            if_flush   = 1'b1;
            state_nxt  = RUN;
        end else if (exc | eret) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            state_nxt = REDIRECT;
        end else if (lu) begin
            // hold IF/ID and push a bubble into EX
            if_stall = 1'b1;
            id_stall = 1'b1;
            id_flush = 1'b1;
        end else if (id_br_taken) begin
            if_flush = 1'b1;
        end
    end

    always_comb begin
        new_pc = '0;
        if (state == REDIRECT) begin
            new_pc = to_vec ? EXC_VECTOR : epc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            to_vec     <= 1'b0;
            epc        <= '0;
            exp_cause  <= '0;
            in_handler <= 1'b0;
        end else begin
            state <= state_nxt;
            if (run_ok & exc) begin
                epc        <= mem_pc;
                exp_cause  <= mem_exp_code;
                in_handler <= 1'b1;
                to_vec     <= 1'b1;
            end else if (run_ok & eret) begin
                in_handler <= 1'b0;
                to_vec     <= 1'b0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic flush_ev;

    assign flush_ev = run_ok & (exc | eret | (~lu & id_br_taken));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (gs | lu) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_ev) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 4-stage integer core (IF/ID/EX/MEM). It generates the stall and flush controls consumed by every pipeline register, and detects load-use hazards and taken-branch kills. It sequences exception entry and return through a small FSM, holding the exception PC and cause, and it drives PC redirection to the IF stage.

Parameters:
ADDR_W, 30, word-address width of PCs
REG_W, 5, GPR address width
EXP_W, 3, exception code width (0 = no exception)
EXC_VECTOR, 30'h0000_0010, word address of exception handler

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_busy  in  1  IF bus access not complete
mem_busy  in  1  MEM bus access not complete
id_src0_addr  in  REG_W  ID source register 0
id_src1_addr  in  REG_W  ID source register 1
id_src_use  in  2  per-source "register actually read" flags
id_br_taken  in  1  ID resolved a taken branch/jump
ex_en  in  1  EX stage entry valid
ex_is_load  in  1  EX entry is a memory load
ex_gpr_we_  in  1  EX entry GPR write enable, active-low
ex_dst_addr  in  REG_W  EX entry destination
mem_en  in  1  MEM stage entry valid
mem_pc  in  ADDR_W  MEM stage PC
mem_exp_code  in  EXP_W  MEM stage exception code
mem_eret  in  1  MEM stage entry is exception return
if_stall, id_stall, ex_stall, mem_stall  out  1 each  pipeline register hold
if_flush, id_flush, ex_flush, mem_flush  out  1 each  pipeline register clear to NOP
new_pc  out  ADDR_W  redirect target
new_pc_vld  out  1  IF must load new_pc this cycle
epc  out  ADDR_W  saved exception PC
exp_cause  out  EXP_W  saved exception code
in_handler  out  1  exception being serviced (set on entry, cleared by eret)

Behaviour:
- Reset: FSM=RUN. epc=0, exp_cause=0, in_handler=0. All registered outputs 0.
- Stall/flush outputs are combinational from the FSM state and inputs. epc, exp_cause and in_handler are registered.
- Global stall (gs): gs = if_busy | mem_busy. While gs=1:
  - all four *_stall=1 and all *_flush=0;
  - new_pc_vld=0;
  - no event is accepted and the FSM holds state.
- Load-use hazard (lu):
  - lu = ex_en & ex_is_load & !ex_gpr_we_ & ex_dst_addr!=0 & ((id_src_use[0] & id_src0_addr==ex_dst_addr) | (id_src_use[1] & id_src1_addr==ex_dst_addr)).
  - In RUN with gs=0: if_stall=1, id_stall=1, id_flush=1 (bubble into EX). One cycle per occurrence.
- Branch kill: in RUN with gs=0 and lu=0, id_br_taken=1 gives if_flush=1. lu has priority; the branch is re-evaluated next cycle.
- Exception: in RUN with gs=0, mem_en=1 and mem_exp_code!=0:
  - same cycle: all four *_flush=1;
  - registers capture epc<=mem_pc, exp_cause<=mem_exp_code, in_handler<=1;
  - next state REDIRECT.
  - Exception beats eret, lu and branch.
- Eret: in RUN with gs=0, mem_en=1, mem_eret=1 and no exception:
  - all *_flush=1;
  - in_handler<=0;
  - next state REDIRECT with target epc.
- REDIRECT (1 cycle, gs=0):
  - new_pc_vld=1, if_flush=1, other flushes 0;
  - new_pc = EXC_VECTOR after an exception, epc after an eret (1-bit target select register);
  - next state RUN.
  - If gs=1 in REDIRECT, stay and retry.
- Outside REDIRECT: new_pc_vld=0, new_pc=0.
- An exception while in_handler=1 overwrites epc/exp_cause (no nesting stack).
- Reset asserted mid-REDIRECT returns to RUN with no redirect issued.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- With it defined: 32-bit outputs stall_cnt and flush_cnt.
  - stall_cnt increments each cycle gs|lu=1.
  - flush_cnt increments once per exception, eret or branch kill.
  - Both wrap at 2^32-1 to 0 and reset to 0.
- Without it: ports and counters are absent.

Test Plan:
- Load-use: ex_is_load=1, ex_gpr_we_=0, ex_dst_addr=5, id_src0_addr=5, id_src_use=01 -> one cycle if_stall=id_stall=id_flush=1, others 0. Same with ex_dst_addr=0 -> no stall.
- Branch: id_br_taken=1, no hazard -> if_flush=1 only. Branch with lu simultaneous -> lu response only.
- Exception: mem_exp_code=3, mem_pc=30'h100 -> all flushes=1, then next cycle new_pc_vld=1, new_pc=30'h10; epc=30'h100, exp_cause=3, in_handler=1.
- Eret after exception -> all flushes, then new_pc_vld=1, new_pc=30'h100, in_handler=0.
- Busy: mem_busy=1 during exception or lu -> all stalls=1, no flush/redirect; event is taken when mem_busy drops.
- Reset during REDIRECT -> new_pc_vld=0 next cycle, epc=0, FSM in RUN.
